// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle logic ops plus iterative multu and optional divu.
// Define ALU_SEQ_DIV_EN to compile in the restoring divider (opcode 1001); otherwise 1001 is undefined.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;      // multiplier->product low half / dividend->quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand or divisor
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zero_q, zero_d, dbz_q, dbz_d, done_q, done_d;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_sh, it_acc, it_sh;

  // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_acc = mul_sum[WIDTH:1];
    mul_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_acc, div_sh;

  // Restoring step: shift in the next dividend bit, keep the trial difference if it fits.
  always_comb begin
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_acc   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_sh    = {sh_q[WIDTH-2:0], div_ge};
  end

  assign it_acc = is_div_q ? div_acc : mul_acc;
  assign it_sh  = is_div_q ? div_sh  : mul_sh;
`else
  assign it_acc = mul_acc;
  assign it_sh  = mul_sh;
`endif

  always_comb begin
    case (alu_ctrl)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    is_div_d = is_div_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (alu_ctrl == OP_MUL) begin
            opnd_d  = a;
            sh_d    = b;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH-1);
            state_d = RUN;
`ifdef ALU_SEQ_DIV_EN
            is_div_d = 1'b0;
          end else if (alu_ctrl == OP_DIV) begin
            opnd_d   = b;
            sh_d     = a;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH-1);
            is_div_d = 1'b1;
            state_d  = RUN;
`endif
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            zero_d   = (alu_res == '0);
            dbz_d    = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      RUN: begin
        acc_d = it_acc;
        sh_d  = it_sh;
        if (cnt_q == '0) begin
          result_d = it_sh;
          hi_d     = it_acc;
          zero_d   = (it_sh == '0);
`ifdef ALU_SEQ_DIV_EN
          dbz_d    = is_div_q && (opnd_q == '0);
`else
          dbz_d    = 1'b0;
`endif
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign ready       = (state_q == IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, a negedge monitor pops on done.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] a = 0, b = 0;
  logic [3:0]   alu_ctrl = 0;
  logic         ready, done, zero, div_by_zero;
  logic [W-1:0] result, hi;

  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    logic [W-1:0] res, hi;
    logic         z, dbz;
    int           cyc;
    logic [3:0]   op;
  } exp_t;
  exp_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_ctrl(alu_ctrl),
    .ready(ready), .done(done), .result(result), .hi(hi), .zero(zero),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain arithmetic on the opcode's meaning, plus completion latency.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int c0);
    exp_t e;
    longint unsigned p;
    e.res = 0; e.hi = 0; e.dbz = 0; e.cyc = c0; e.op = op;
    case (op)
      4'b0010: e.res = x + y;
      4'b0110: e.res = x - y;
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0111: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
      4'b1000: begin
        p = longint'(x) * longint'(y);
        e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.cyc = c0 + W;
      end
`ifdef ALU_SEQ_DIV_EN
      4'b1001: begin
        if (y == 0) begin e.res = '1; e.hi = x; e.dbz = 1; end
        else begin e.res = x / y; e.hi = x % y; end
        e.cyc = c0 + W;
      end
`endif
      default: ;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done=1 at cyc=%0d, want no pending op", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || hi !== e.hi || zero !== e.z || div_by_zero !== e.dbz || cyc != e.cyc) begin
          bad++;
          $display("FAIL op%b: got res=%h hi=%h z=%b dbz=%b cyc=%0d want res=%h hi=%h z=%b dbz=%b cyc=%0d",
                   e.op, result, hi, zero, div_by_zero, cyc, e.res, e.hi, e.z, e.dbz, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int g = 0;
    @(negedge clk);
    while (!ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) check("ready_timeout", 0, 1);
    start = 1; alu_ctrl = op; a = x; b = y;
    @(posedge clk); #1;
    sb.push_back(model(op, x, y, cyc));
    start = 0; a = $urandom; b = $urandom;
  endtask

  // Multi-cycle op: ready must stay low for exactly W sampled cycles; a mid-run start is ignored.
  task automatic run_multi(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    issue(op, x, y);
    forever begin
      @(negedge clk);
      if (ready || n >= 200) break;
      n++;
      if (n == 5) begin start = 1; alu_ctrl = 4'b0010; a = 1; b = 1; end
      if (n == 6) start = 0;
    end
    start = 0;
    check("ready_low_cycles", n, W);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin @(negedge clk); g++; end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    logic [3:0] ops [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b1001, 4'b1111};
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_hi", hi, 0);
    check("rst_zero", zero, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1;

    issue(4'b0010, 5, 7);
    issue(4'b0110, 9, 9);
    issue(4'b0111, 32'hFFFF_FFFF, 1);
    issue(4'b0111, 1, 32'hFFFF_FFFF);
    issue(4'b1111, 3, 4);
    run_multi(4'b1000, 32'hFFFF_FFFF, 2);
`ifdef ALU_SEQ_DIV_EN
    run_multi(4'b1001, 100, 7);
    run_multi(4'b1001, 32'h1234, 0);
`else
    issue(4'b1001, 100, 7);
    issue(4'b1001, 32'h1234, 0);
`endif
    drain();

    // Reset in the middle of a multiply
    issue(4'b1000, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    sb.delete();
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_hi", hi, 0);
    check("midrst_zero", zero, 0);
    check("midrst_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1;
    issue(4'b0010, 1, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] x, y;
      op = ops[$urandom_range(0, 7)];
      if (op == 4'b1111) op = 4'($urandom);
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 0;
        1: x = '1;
        2: y = $urandom_range(1, 15);
        default: ;
      endcase
      issue(op, x, y);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle datapath ALU for the MIPS core. Executes the existing one-cycle operations (add, sub, and, or, slt) with registered outputs and a start/done handshake. Adds iterative unsigned multiply (shift-add) and optional unsigned divide (restoring), with HI/LO-style results. Sits in the execute stage; control stalls on `ready` low while a multi-cycle op is in flight.

## Interface
- `WIDTH`, default 32: operand/result width in bits; must be ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only on an edge where `start && ready`.
- `a`  in  WIDTH  operand 1; sampled on acceptance.
- `b`  in  WIDTH  operand 2; sampled on acceptance.
- `alu_ctrl`  in  4  operation select; sampled on acceptance.
- `ready`  out  1  high when idle and able to accept.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `result`  out  WIDTH  primary result (LO for mul, quotient for div).
- `hi`  out  WIDTH  upper product for mul, remainder for div, 0 otherwise.
- `zero`  out  1  registered `result == 0`.
- `div_by_zero`  out  1  set with `done` when a divide had `b == 0`.

## Operation
- Opcodes:
  - 0010 add.
  - 0110 sub, mod 2^WIDTH.
  - 0000 and.
  - 0001 or.
  - 0111 slt, **signed** two's-complement compare, result 1/0.
  - 1000 multu.
  - 1001 divu.
  - Any other code: `result` = 0 and `hi` = 0, completing as a single-cycle op.
- States:
  - IDLE: `ready` = 1.
  - RUN: `ready` = 0, iteration counter counts down from WIDTH−1.
- IDLE with a single-cycle op accepted:
  - Compute and latch `result`, `hi` = 0, `zero`, `div_by_zero` = 0.
  - `done` = 1 for the next cycle; stay in IDLE.
- IDLE with multu/divu accepted:
  - Latch operands, clear the accumulators, enter RUN.
- RUN:
  - One iteration (one bit) per edge.
  - On the edge where the counter reaches 0: write `result`/`hi`/`zero`/`div_by_zero`, pulse `done`, return to IDLE.
- multu: full 2·WIDTH unsigned product; `hi` gets the upper half, `result` the lower half.
- divu: quotient → `result`, remainder → `hi`.
- Divide by zero: no special path. The restoring algorithm yields quotient all-ones and remainder = `a`; `div_by_zero` = 1 for that result.
- Outputs hold their values until the next completing operation. Operand changes while busy have no effect.
- `start` while `ready` = 0 is ignored (no queueing).
- Reset (any time, including mid-RUN):
  - Abort the operation; state IDLE.
  - `ready` = 1, `done` = 0, `result` = 0, `hi` = 0, `zero` = 0, `div_by_zero` = 0.

## Timing
- Acceptance edge E0: `start && ready` sampled high.
- Single-cycle ops:
  - Outputs update at E0; `done` is high for the cycle E0→E1.
  - `ready` stays 1, so back-to-back ops are allowed every cycle.
- multu/divu:
  - `ready` falls at E0.
  - The iterations complete on edges E1..E_WIDTH.
  - Outputs update and `done` rises at E_WIDTH; `ready` returns to 1 at the same edge.
  - A new op can be accepted at E_WIDTH+1 if `start` is held.
  - Latency is WIDTH cycles (32 for the default).
- `done` never stays high for more than one cycle per operation.
- `zero` is always consistent with the registered `result`.

## Configuration
- `ALU_SEQ_DIV_EN` defined:
  - The divu datapath (remainder register, trial subtractor) is compiled in.
  - Opcode 1001 behaves as specified above.
- `ALU_SEQ_DIV_EN` undefined:
  - No divide hardware.
  - Opcode 1001 is treated as an undefined opcode: single-cycle, `result` = 0, `hi` = 0, `div_by_zero` = 0.

## Test plan
- Reset, then release: `ready` = 1 and all other outputs 0. Add `a`=5, `b`=7 → `result` = 12, `zero` = 0, `done` pulsed one cycle after E0. Immediately follow with sub 9−9 → `result` = 0, `zero` = 1.
- slt `a`=0xFFFFFFFF, `b`=1 → `result` = 1 (signed −1 < 1). Swapped operands → `result` = 0.
- multu 0xFFFFFFFF × 2 → after 32 cycles `hi` = 0x00000001, `result` = 0xFFFFFFFE. `ready` is 0 for exactly 32 cycles, and a `start` pulse mid-run is ignored.
- divu 100 / 7 → `result` = 14, `hi` = 2, `div_by_zero` = 0. divu 0x1234 / 0 → `result` = 0xFFFFFFFF, `hi` = 0x1234, `div_by_zero` = 1. Without `ALU_SEQ_DIV_EN`: `result` = 0 with `done` one cycle after acceptance.
- Assert `rst_n` low at iteration 10 of a multu → immediate return to reset values. After release, an add 1+1 → 2 completes normally.
- Opcode 1111 with `a`=3, `b`=4 → `result` = 0, `hi` = 0, `zero` = 1, single-cycle `done`.
